pir_motion_source: RTL and testbench

Stimulus-side source for the PIR motion detector: produces the three 7-bit sensor sample streams (`pir_sensor_1..3`) that the detector consumes. Three independent per-channel event engines are scheduled over a valid/ready command port. Between events each channel outputs an LFSR noise baseline. During an event it outputs a programmable amplitude plus noise, saturated to 7 bits. The block sits in the simulation top and in FPGA self-test builds in place of the physical sensors.

---
 rtl/pir_motion_source.sv | 190 +++++++++++++++++++
 tb/tb_pir_motion_source.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pir_motion_source.sv
// pir_motion_source: three-channel PIR sensor stimulus source. Each channel
// idles on an LFSR noise baseline and, when commanded, plays a delayed,
// fixed-length elevated event (amplitude + noise, saturated to 7 bits).
module pir_motion_source #(
  parameter int unsigned SAMPLE_PERIOD = 4,
  parameter logic [6:0]  NOISE_MASK    = 7'h0F,
  parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       noise_en,
  input  logic       abort,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_sensor,
  input  logic [6:0] cmd_amplitude,
  input  logic [7:0] cmd_delay,
  input  logic [7:0] cmd_duration,
  output logic [6:0] pir_sensor_1,
  output logic [6:0] pir_sensor_2,
  output logic [6:0] pir_sensor_3,
  output logic       sample_strobe,
  output logic [2:0] event_active,
  output logic [2:0] event_done,
  output logic       cmd_error,
  output logic [7:0] events_total
);

  localparam int unsigned CW = $clog2(SAMPLE_PERIOD);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACTIVE = 2'd2
  } ch_state_t;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick;
  logic [7:0]    lfsr_q, lfsr_d;

  ch_state_t     st_q  [3];
  ch_state_t     st_d  [3];
  logic [6:0]    amp_q [3];
  logic [6:0]    amp_d [3];
  logic [7:0]    dly_q [3];
  logic [7:0]    dly_d [3];
  logic [7:0]    rem_q [3];
  logic [7:0]    rem_d [3];
  logic [6:0]    smp_q [3];
  logic [6:0]    smp_d [3];
  logic [6:0]    noise [3];
  logic [6:0]    sat   [3];
  logic [7:0]    sum   [3];

  logic          strobe_q;
  logic [2:0]    done_q, done_d;
  logic          err_q, err_d;
  logic [7:0]    total_q, total_d;
  logic          sel_idle;
  logic          accept;

  // Sample tick generation and LFSR advance (8-bit Fibonacci, taps 8,6,5,4)
  always_comb begin
    tick   = enable && (cnt_q == CW'(SAMPLE_PERIOD - 1));
    cnt_d  = cnt_q;
    if (enable) cnt_d = tick ? '0 : cnt_q + CW'(1);
    lfsr_d = lfsr_q;
    if (tick) lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  // Per-channel noise (LFSR rotated left by 2k) and saturated event level
  always_comb begin
    noise[0] = lfsr_q[6:0];
    noise[1] = {lfsr_q[4:0], lfsr_q[7:6]};
    noise[2] = {lfsr_q[2:0], lfsr_q[7:4]};
    for (int unsigned k = 0; k < 3; k++) begin
      noise[k] = noise_en ? (noise[k] & NOISE_MASK) : '0;
      sum[k]   = {1'b0, amp_q[k]} + {1'b0, noise[k]};
      sat[k]   = sum[k][7] ? 7'h7F : sum[k][6:0];
    end
  end

  // Command handshake: sensor 3 is always acceptable (and dropped)
  always_comb begin
    case (cmd_sensor)
      2'd0:    sel_idle = (st_q[0] == ST_IDLE);
      2'd1:    sel_idle = (st_q[1] == ST_IDLE);
      2'd2:    sel_idle = (st_q[2] == ST_IDLE);
      default: sel_idle = 1'b1;
    endcase
    cmd_ready = rst_n & ~abort & sel_idle;
    accept    = cmd_valid & cmd_ready;
    err_d     = accept && (cmd_sensor == 2'd3);
  end

  // Channel event engines: tick processing, command load, abort override
  always_comb begin
    done_d = '0;
    for (int unsigned k = 0; k < 3; k++) begin
      st_d[k]  = st_q[k];
      amp_d[k] = amp_q[k];
      dly_d[k] = dly_q[k];
      rem_d[k] = rem_q[k];
      smp_d[k] = smp_q[k];
      if (tick) begin
        case (st_q[k])
          ST_IDLE: smp_d[k] = noise[k];
          ST_WAIT: begin
            smp_d[k] = noise[k];
            dly_d[k] = dly_q[k] - 8'd1;
            if (dly_q[k] == 8'd1) st_d[k] = ST_ACTIVE;
          end
          ST_ACTIVE: begin
            smp_d[k] = sat[k];
            rem_d[k] = rem_q[k] - 8'd1;
            if (rem_q[k] == 8'd1) begin
              st_d[k]   = ST_IDLE;
              done_d[k] = 1'b1;
            end
          end
          default: st_d[k] = ST_IDLE;
        endcase
      end
      // Only an idle channel can be loaded, so this never collides with
      // an in-flight tick update of the same channel.
      if (accept && (cmd_sensor == 2'(k))) begin
        amp_d[k] = cmd_amplitude;
        dly_d[k] = cmd_delay;
        rem_d[k] = (cmd_duration == 8'd0) ? 8'd1 : cmd_duration;
        st_d[k]  = (cmd_delay == 8'd0) ? ST_ACTIVE : ST_WAIT;
      end
      // Abort wins over completion: a tick on the abort edge carries baseline only.
      if (abort) begin
        st_d[k]   = ST_IDLE;
        done_d[k] = 1'b0;
        if (tick) smp_d[k] = noise[k];
      end
    end
    total_d = total_q + 8'(done_d[0]) + 8'(done_d[1]) + 8'(done_d[2]);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      lfsr_q   <= LFSR_SEED;
      strobe_q <= 1'b0;
      done_q   <= '0;
      err_q    <= 1'b0;
      total_q  <= '0;
      for (int unsigned k = 0; k < 3; k++) begin
        st_q[k]  <= ST_IDLE;
        amp_q[k] <= '0;
        dly_q[k] <= '0;
        rem_q[k] <= '0;
        smp_q[k] <= '0;
      end
    end else begin
      cnt_q    <= cnt_d;
      lfsr_q   <= lfsr_d;
      strobe_q <= tick;
      done_q   <= done_d;
      err_q    <= err_d;
      total_q  <= total_d;
      for (int unsigned k = 0; k < 3; k++) begin
        st_q[k]  <= st_d[k];
        amp_q[k] <= amp_d[k];
        dly_q[k] <= dly_d[k];
        rem_q[k] <= rem_d[k];
        smp_q[k] <= smp_d[k];
      end
    end
  end

  // Output mapping
  always_comb begin
    pir_sensor_1  = smp_q[0];
    pir_sensor_2  = smp_q[1];
    pir_sensor_3  = smp_q[2];
    sample_strobe = strobe_q;
    event_done    = done_q;
    cmd_error     = err_q;
    events_total  = total_q;
    for (int unsigned k = 0; k < 3; k++) begin
      event_active[k] = (st_q[k] == ST_ACTIVE);
    end
  end

endmodule

// File: tb/tb_pir_motion_source.sv
// tb_pir_motion_source: directed scenarios plus a randomized run, every cycle
// compared against a per-channel schedule model (list of per-tick levels).
module tb_pir_motion_source;

  logic       clk = 1'b0;
  logic       rst_n, enable, noise_en, abort, cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_sensor;
  logic [6:0] cmd_amplitude;
  logic [7:0] cmd_delay, cmd_duration;
  logic [6:0] pir_sensor_1, pir_sensor_2, pir_sensor_3;
  logic       sample_strobe;
  logic [2:0] event_active, event_done;
  logic       cmd_error;
  logic [7:0] events_total;

  pir_motion_source #(
    .SAMPLE_PERIOD(4),
    .NOISE_MASK   (7'h0F),
    .LFSR_SEED    (8'hA5)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .noise_en     (noise_en),
    .abort        (abort),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_sensor   (cmd_sensor),
    .cmd_amplitude(cmd_amplitude),
    .cmd_delay    (cmd_delay),
    .cmd_duration (cmd_duration),
    .pir_sensor_1 (pir_sensor_1),
    .pir_sensor_2 (pir_sensor_2),
    .pir_sensor_3 (pir_sensor_3),
    .sample_strobe(sample_strobe),
    .event_active (event_active),
    .event_done   (event_done),
    .cmd_error    (cmd_error),
    .events_total (events_total)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: each channel owns a list of per-tick levels
  // (-1 = baseline tick, otherwise the event amplitude) consumed one per tick.
  int         plan [3][512];
  int         plen [3];
  int         ppos [3];
  logic [7:0] m_lfsr;
  int         m_en;
  int         m_smp [3];
  bit         m_strobe;
  bit   [2:0] m_done;
  bit         m_err;
  int         m_total;
  bit         m_acc_last;

  function automatic bit busy(input int k);
    return ppos[k] < plen[k];
  endfunction

  function automatic int noise_of(input int k);
    logic [15:0] d;
    logic [7:0]  r;
    d = {m_lfsr, m_lfsr};
    r = d[15 - 2*k -: 8];
    if (!noise_en) return 0;
    return int'(r[6:0] & 7'h0F);
  endfunction

  task automatic model_reset();
    m_lfsr = 8'hA5; m_en = 0; m_strobe = 0; m_done = '0; m_err = 0; m_total = 0;
    for (int k = 0; k < 3; k++) begin
      m_smp[k] = 0; plen[k] = 0; ppos[k] = 0;
    end
  endtask

  // One clock: check cmd_ready, advance the model over the edge, check outputs.
  task automatic step();
    bit   rdy, tick, acc;
    int   lv, nz, n;
    logic [2:0] exp_act;
    #1;
    rdy = rst_n && !abort && (cmd_sensor == 2'd3 || !busy(int'(cmd_sensor)));
    check("cmd_ready", {31'b0, cmd_ready}, {31'b0, rdy});
    acc = cmd_valid && rdy;
    m_acc_last = acc;
    if (!rst_n) begin
      model_reset();
    end else begin
      tick = enable && (m_en % 4 == 3);
      m_strobe = tick; m_done = '0; m_err = 0;
      if (tick) begin
        for (int k = 0; k < 3; k++) begin
          nz = noise_of(k);
          if (abort || !busy(k)) m_smp[k] = nz;
          else begin
            lv = plan[k][ppos[k]];
            ppos[k]++;
            if (lv < 0) m_smp[k] = nz;
            else begin
              m_smp[k] = (lv + nz > 127) ? 127 : lv + nz;
              if (ppos[k] == plen[k]) m_done[k] = 1'b1;
            end
          end
        end
      end
      if (abort) for (int k = 0; k < 3; k++) begin plen[k] = 0; ppos[k] = 0; end
      m_total = (m_total + m_done[0] + m_done[1] + m_done[2]) % 256;
      if (acc) begin
        if (cmd_sensor == 2'd3) m_err = 1;
        else begin
          lv = int'(cmd_sensor);
          plen[lv] = 0; ppos[lv] = 0;
          for (int i = 0; i < int'(cmd_delay); i++) begin plan[lv][plen[lv]] = -1; plen[lv]++; end
          n = (cmd_duration == 0) ? 1 : int'(cmd_duration);
          for (int i = 0; i < n; i++) begin plan[lv][plen[lv]] = int'(cmd_amplitude); plen[lv]++; end
        end
      end
      if (tick) m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
      if (enable) m_en++;
    end
    for (int k = 0; k < 3; k++) exp_act[k] = busy(k) && (plan[k][ppos[k]] >= 0);
    @(posedge clk);
    #1;
    check("pir_sensor_1", {25'b0, pir_sensor_1}, m_smp[0]);
    check("pir_sensor_2", {25'b0, pir_sensor_2}, m_smp[1]);
    check("pir_sensor_3", {25'b0, pir_sensor_3}, m_smp[2]);
    check("sample_strobe", {31'b0, sample_strobe}, {31'b0, m_strobe});
    check("event_done", {29'b0, event_done}, {29'b0, m_done});
    check("event_active", {29'b0, event_active}, {29'b0, exp_act});
    check("cmd_error", {31'b0, cmd_error}, {31'b0, m_err});
    check("events_total", {24'b0, events_total}, m_total);
  endtask

  task automatic idle(input int n);
    cmd_valid = 1'b0;
    repeat (n) step();
  endtask

  // Hold a command until accepted, bounded by a cycle budget.
  task automatic send(input int s, input int a, input int d, input int n);
    cmd_sensor = 2'(s); cmd_amplitude = 7'(a); cmd_delay = 8'(d); cmd_duration = 8'(n);
    cmd_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      step();
      if (m_acc_last) break;
    end
    check("send_accepted", {31'b0, m_acc_last}, 32'd1);
    cmd_valid = 1'b0;
  endtask

  int base;

  initial begin
    rst_n = 0; enable = 1; noise_en = 0; abort = 0; cmd_valid = 0;
    cmd_sensor = 0; cmd_amplitude = 0; cmd_delay = 0; cmd_duration = 0;
    model_reset();
    repeat (2) step();
    rst_n = 1;
    idle(12);

    send(0, 60, 2, 3);
    idle(30);
    check("total_after_ch0", {24'b0, events_total}, 32'd1);

    noise_en = 1;
    send(1, 120, 1, 5);
    idle(40);

    send(2, 50, 3, 2);
    send(0, 30, 0, 2);
    send(2, 40, 0, 1);
    idle(30);

    for (int i = 0; i < 8 && (m_en % 4 != 0); i++) step();
    base = m_total;
    send(0, 10, 0, 1);
    send(1, 20, 0, 1);
    send(2, 30, 0, 1);
    step();
    check("triple_done", {29'b0, event_done}, 32'd7);
    check("triple_total", {24'b0, events_total}, (base + 3) % 256);
    idle(8);

    base = m_total;
    send(1, 70, 0, 10);
    idle(8);
    abort = 1; step(); abort = 0;
    idle(50);
    check("abort_total", {24'b0, events_total}, base);

    send(0, 80, 0, 10);
    idle(8);
    rst_n = 0; step(); rst_n = 1;
    check("reset_total", {24'b0, events_total}, 32'd0);
    idle(10);

    send(3, 5, 5, 5);
    check("cmd_error_pulse", {31'b0, cmd_error}, 32'd1);
    idle(5);

    enable = 0;
    send(2, 90, 0, 2);
    idle(10);
    enable = 1;
    idle(20);

    for (int i = 0; i < 800; i++) begin
      rst_n         = ($urandom_range(0, 99) != 0);
      enable        = ($urandom_range(0, 9) != 0);
      noise_en      = 1'($urandom_range(0, 1));
      abort         = ($urandom_range(0, 49) == 0);
      cmd_valid     = ($urandom_range(0, 2) == 0);
      cmd_sensor    = 2'($urandom_range(0, 3));
      cmd_amplitude = 7'($urandom);
      cmd_delay     = 8'($urandom_range(0, 4));
      cmd_duration  = 8'($urandom_range(0, 5));
      step();
    end
    rst_n = 1; abort = 0; enable = 1;
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
